// File: rtl/timer_irq_ctrl_if.sv
// Bus, interrupt-line and cause signals between the core side and timer_irq_ctrl.
// The slave modport is the timer block; master is the core/bus side.
interface timer_irq_ctrl_if;
   logic        sel;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ext_irq;
   logic        irq_ack;
   logic [31:0] cause;
   logic        irq;

   modport slave (
      input  sel, we, addr, wdata, ext_irq, irq_ack,
      output rdata, cause, irq
   );

   modport master (
      output sel, we, addr, wdata, ext_irq, irq_ack,
      input  rdata, cause, irq
   );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Machine timer (prescaled 64-bit mtime/mtimecmp) plus external irq, producing the registered CSR cause word.
// Define EXT_IRQ_SYNC_EN to pass ext_irq through a 2-flop synchroniser before edge detection.
module timer_irq_ctrl #(
   parameter int unsigned PRESCALE     = 1,
   parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input logic           clk,
   input logic           rst,
   timer_irq_ctrl_if.slave bus
);
   localparam logic [31:0] CAUSE_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TMR = 32'h8000_0007;
   localparam logic [15:0] PS_LAST   = 16'(PRESCALE - 1);

   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_STATUS   = 3'd5;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        meip_q, meip_d;
   logic [31:0] cause_q, cause_d;
   logic        edge_q;
   logic        ext_in;
   logic        mtip;
   logic        rise;
   logic        wr;
   logic [2:0]  widx;
   logic        unused_addr;

   assign wr          = bus.sel & bus.we;
   assign widx        = bus.addr[4:2];
   assign unused_addr = ^bus.addr[1:0];
   assign mtip        = (mtime_q >= mtimecmp_q);

`ifdef EXT_IRQ_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.ext_irq;
         sync2_q <= sync1_q;
      end
   end

   assign ext_in = sync2_q;
`else
   assign ext_in = bus.ext_irq;
`endif

   assign rise = ext_in & ~edge_q;

   always_comb begin
      mtime_d    = mtime_q;
      pcnt_d     = pcnt_q;
      mtimecmp_d = mtimecmp_q;
      ctrl_d     = ctrl_q;

      // A bus write to either mtime half wins over counting and restarts the prescaler.
      if (wr && widx == A_MTIME_LO) begin
         mtime_d[31:0] = bus.wdata;
         pcnt_d        = 16'd0;
      end else if (wr && widx == A_MTIME_HI) begin
         mtime_d[63:32] = bus.wdata;
         pcnt_d         = 16'd0;
      end else if (ctrl_q[0]) begin
         if (pcnt_q == PS_LAST) begin
            pcnt_d  = 16'd0;
            mtime_d = mtime_q + 64'd1;
         end else begin
            pcnt_d = pcnt_q + 16'd1;
         end
      end

      if (wr && widx == A_CMP_LO) mtimecmp_d[31:0]  = bus.wdata;
      if (wr && widx == A_CMP_HI) mtimecmp_d[63:32] = bus.wdata;
      if (wr && widx == A_CTRL)   ctrl_d            = bus.wdata[2:0];
   end

   always_comb begin
      meip_d = meip_q;
      if ((bus.irq_ack && cause_q == CAUSE_EXT) || (wr && widx == A_STATUS && bus.wdata[1]))
         meip_d = 1'b0;
      if (rise)
         meip_d = 1'b1;

      if (meip_q && ctrl_q[2])
         cause_d = CAUSE_EXT;
      else if (mtip && ctrl_q[1])
         cause_d = CAUSE_TMR;
      else
         cause_d = 32'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= 64'h0;
         mtimecmp_q <= MTIMECMP_RST;
         pcnt_q     <= 16'd0;
         ctrl_q     <= 3'b000;
         meip_q     <= 1'b0;
         cause_q    <= 32'h0;
         edge_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         pcnt_q     <= pcnt_d;
         ctrl_q     <= ctrl_d;
         meip_q     <= meip_d;
         cause_q    <= cause_d;
         edge_q     <= ext_in;
      end
   end

   always_comb begin
      bus.rdata = 32'h0;
      if (bus.sel) begin
         case (widx)
            A_MTIME_LO: bus.rdata = mtime_q[31:0];
            A_MTIME_HI: bus.rdata = mtime_q[63:32];
            A_CMP_LO:   bus.rdata = mtimecmp_q[31:0];
            A_CMP_HI:   bus.rdata = mtimecmp_q[63:32];
            A_CTRL:     bus.rdata = {29'h0, ctrl_q};
            A_STATUS:   bus.rdata = {30'h0, meip_q, mtip};
            default:    bus.rdata = 32'h0;
         endcase
      end
   end

   assign bus.cause = cause_q;
   assign bus.irq   = cause_q[31];
endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Two DUTs (PRESCALE 1 and 4) share one random/directed stimulus stream and are checked against a behavioural model.
module tb_timer_irq_ctrl;
`ifdef EXT_IRQ_SYNC_EN
   localparam int D = 2;
   localparam int LATC = 3;
`else
   localparam int D = 0;
   localparam int LATC = 1;
`endif
   localparam logic [31:0] CE = 32'h8000_000B;
   localparam logic [31:0] CT = 32'h8000_0007;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0, we = 1'b0, ext = 1'b0, ack = 1'b0;
   logic [4:0] addr = 5'd0;
   logic [31:0] wdata = 32'h0;

   int n_vec = 0;
   int n_err = 0;

   timer_irq_ctrl_if b1 ();
   timer_irq_ctrl_if b4 ();

   assign b1.sel = sel;  assign b1.we = we;  assign b1.addr = addr;  assign b1.wdata = wdata;
   assign b1.ext_irq = ext;  assign b1.irq_ack = ack;
   assign b4.sel = sel;  assign b4.we = we;  assign b4.addr = addr;  assign b4.wdata = wdata;
   assign b4.ext_irq = ext;  assign b4.irq_ack = ack;

   timer_irq_ctrl #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
   timer_irq_ctrl #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

   always #5 clk = ~clk;

   // Model: mtime = value last written + (enabled cycles since that write) / PRESCALE.
   longint unsigned m_base [2];
   longint unsigned m_cnt  [2];
   logic [63:0]     m_cmp  [2];
   logic [2:0]      m_ctrl [2];
   logic            m_meip [2];
   logic [31:0]     m_cause[2];
   int              ps     [2] = '{1, 4};
   logic [3:0]      hist;

   function automatic logic [63:0] m_mtime(int i);
      return m_base[i] + m_cnt[i] / longint'(ps[i]);
   endfunction

   function automatic logic [31:0] m_rdata(int i);
      logic [63:0] mt;
      mt = m_mtime(i);
      if (!sel) return 32'h0;
      case (addr[4:2])
         3'd0: return mt[31:0];
         3'd1: return mt[63:32];
         3'd2: return m_cmp[i][31:0];
         3'd3: return m_cmp[i][63:32];
         3'd4: return {29'h0, m_ctrl[i]};
         3'd5: return {30'h0, m_meip[i], (mt >= m_cmp[i])};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_base[i] = 0; m_cnt[i] = 0; m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
         m_ctrl[i] = 3'b000; m_meip[i] = 1'b0; m_cause[i] = 32'h0;
      end
      hist = 4'b0000;
   endtask

   task automatic model_edge();
      logic rise_now, mtip, clr, w;
      logic [63:0] mt;
      logic [31:0] nc;
      hist = {hist[2:0], ext};
      rise_now = hist[D] & ~hist[D+1];
      w = sel & we;
      for (int i = 0; i < 2; i++) begin
         mt = m_mtime(i);
         mtip = (mt >= m_cmp[i]);
         nc = (m_meip[i] && m_ctrl[i][2]) ? CE : ((mtip && m_ctrl[i][1]) ? CT : 32'h0);
         clr = (ack && m_cause[i] == CE) || (w && addr[4:2] == 3'd5 && wdata[1]);
         m_meip[i] = rise_now | (m_meip[i] & ~clr);
         if (w && addr[4:2] == 3'd0) begin
            m_base[i] = {mt[63:32], wdata}; m_cnt[i] = 0;
         end else if (w && addr[4:2] == 3'd1) begin
            m_base[i] = {wdata, mt[31:0]}; m_cnt[i] = 0;
         end else if (m_ctrl[i][0]) begin
            m_cnt[i] = m_cnt[i] + 1;
         end
         if (w && addr[4:2] == 3'd2) m_cmp[i][31:0]  = wdata;
         if (w && addr[4:2] == 3'd3) m_cmp[i][63:32] = wdata;
         if (w && addr[4:2] == 3'd4) m_ctrl[i] = wdata[2:0];
         m_cause[i] = nc;
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, check combinational read, clock, check registered outputs.
   task automatic step(logic s, logic w, logic [4:0] a, logic [31:0] d, logic e, logic k);
      sel = s; we = w; addr = a; wdata = d; ext = e; ack = k;
      #1;
      check("rdata1", b1.rdata, m_rdata(0));
      check("rdata4", b4.rdata, m_rdata(1));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("cause1", b1.cause, m_cause[0]);
      check("cause4", b4.cause, m_cause[1]);
      check("irq1", {31'h0, b1.irq}, {31'h0, m_cause[0][31]});
      check("irq4", {31'h0, b4.irq}, {31'h0, m_cause[1][31]});
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d);
      step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
   endtask

   task automatic peek(logic [4:0] a);
      sel = 1'b1; we = 1'b0; addr = a; ext = 1'b0; ack = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_cause", b1.cause, 32'h0);
      check("rst_irq", {31'h0, b1.irq}, 32'h0);
      peek(5'h00); check("rst_mtime_lo", b1.rdata, 32'h0);
      peek(5'h0C); check("rst_cmp_hi", b1.rdata, 32'hFFFF_FFFF);
      peek(5'h10); check("rst_ctrl", b1.rdata, 32'h0);

      // Timer interrupt one cycle after mtime reaches mtimecmp.
      wr(5'h08, 32'd10);
      wr(5'h0C, 32'd0);
      wr(5'h10, 32'd3);
      found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         peek(5'h00);
         if (b1.rdata == 32'd10) found = 1'b1;
         else idle();
      end
      check("reach10", {31'h0, found}, 32'h1);
      check("cause_at10", b1.cause, 32'h0);
      idle();
      check("cause_tmr", b1.cause, CT);
      check("irq_tmr", {31'h0, b1.irq}, 32'h1);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      idle();
      check("ack_keeps_tmr", b1.cause, CT);
      wr(5'h08, 32'd1000);
      idle();
      check("cmp_raise_cause", b1.cause, 32'h0);
      peek(5'h14); check("cmp_raise_mtip", {31'h0, b1.rdata[0]}, 32'h0);

      // Prescaler: 40 enabled cycles.
      wr(5'h00, 32'd0);
      wr(5'h04, 32'd0);
      repeat (40) idle();
      peek(5'h00);
      check("ps4_mtime", b4.rdata, 32'd10);
      check("ps1_mtime", b1.rdata, 32'd40);

      // 64-bit wrap.
      wr(5'h00, 32'hFFFF_FFFF);
      wr(5'h04, 32'hFFFF_FFFF);
      peek(5'h00); check("wrap_pre_lo", b1.rdata, 32'hFFFF_FFFF);
      peek(5'h14); check("wrap_pre_mtip", {31'h0, b1.rdata[0]}, 32'h1);
      idle();
      peek(5'h00); check("wrap_lo", b1.rdata, 32'h0);
      peek(5'h04); check("wrap_hi", b1.rdata, 32'h0);
      peek(5'h14); check("wrap_mtip", {31'h0, b1.rdata[0]}, 32'h0);

      // Both sources pending: external wins, ack retires it.
      wr(5'h08, 32'd0);
      wr(5'h10, 32'd7);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      repeat (5) idle();
      check("both_ext", b1.cause, CE);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
      idle();
      check("ack_to_tmr", b1.cause, CT);
      peek(5'h14); check("ack_meip", {31'h0, b1.rdata[1]}, 32'h0);

      // External edge with EIE=0: pending but no irq; W1C clear.
      wr(5'h10, 32'd0);
      idle();
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
      for (int n = 1; n <= LATC; n++) begin
         if (n > 1) idle();
         if (n >= LATC - 1) begin
            peek(5'h14);
            check("meip_lat", {31'h0, b1.rdata[1]}, (n == LATC) ? 32'h1 : 32'h0);
         end
      end
      idle();
      check("eie0_irq", {31'h0, b1.irq}, 32'h0);
      wr(5'h14, 32'd2);
      peek(5'h14); check("w1c_meip", {31'h0, b1.rdata[1]}, 32'h0);

      // Asynchronous reset while the timer irq is asserted.
      wr(5'h10, 32'd3);
      idle(); idle();
      check("pre_rst_cause", b1.cause, CT);
      #1 rst = 1'b1;
      #1 check("async_rst_cause", b1.cause, 32'h0);
      peek(5'h00); check("async_rst_mtime", b1.rdata, 32'h0);
      peek(5'h0C); check("async_rst_cmp", b1.rdata, 32'hFFFF_FFFF);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) idle();
      check("post_rst_cause", b1.cause, 32'h0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         logic s, w, e, k;
         logic [4:0] a;
         logic [31:0] d;
         s = 1'($urandom_range(0, 1));
         w = ($urandom_range(0, 3) == 0);
         a = 5'($urandom_range(0, 31));
         case (a[4:2])
            3'd0, 3'd2: d = $urandom_range(0, 80);
            3'd1, 3'd3: d = ($urandom_range(0, 15) == 0) ? $urandom : 32'h0;
            default:    d = $urandom;
         endcase
         e = ($urandom_range(0, 7) == 0) ? ~ext : ext;
         k = ($urandom_range(0, 7) == 0);
         step(s, w, a, d, e, k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/timer_irq_ctrl.md
Name: timer_irq_ctrl

Overview:
- Machine-level interrupt source that sits directly upstream of the CSR register file.
- Holds a memory-mapped 64-bit mtime counter with prescaler, a 64-bit mtimecmp compare register and one external interrupt line.
- Drives the 32-bit cause word consumed by the CSR file; cause[31] set means an interrupt is pending.
- Trap acceptance is reported back on irq_ack so the block can retire the pending external request.

Parameters:
- PRESCALE, 1, core clock cycles per mtime increment; legal range 1..65535.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; the default means no timer interrupt after reset.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- sel  input  1  data-bus select for this block
- we  input  1  write strobe, qualified by sel
- addr  input  5  byte offset, word aligned; addr[1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data, combinational from addr; 0 when sel=0
- ext_irq  input  1  external interrupt request, level, asynchronous to core
- irq_ack  input  1  one-cycle pulse when the core takes an interrupt trap
- cause  output  32  registered cause word to the CSR file
- irq  output  1  equals cause[31]

Behaviour:
- Register map (word offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 TEN (timer count enable), bit1 TIE (timer irq enable), bit2 EIE (external irq enable); other bits read 0
  - 0x14 STATUS: bit0 MTIP, read-only; bit1 MEIP, write-1-to-clear
  - Unmapped offsets read 0; writes to them are ignored.
- Reset values:
  - mtime = 0, mtimecmp = MTIMECMP_RST, CTRL = 0, MEIP = 0, prescale count = 0.
  - cause = 0, irq = 0, synchroniser flops and edge-detect flop = 0.
- Prescaler:
  - Counts 0..PRESCALE-1 while TEN=1.
  - On the wrap cycle, mtime increments by 1 as a full 64-bit add; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - TEN=0 holds both the prescaler and mtime.
  - PRESCALE=1 means mtime increments every cycle.
- Bus write to MTIME_LO or MTIME_HI:
  - Overrides that half and suppresses the increment in that cycle; the other half is unchanged and there is no carry.
  - Resets the prescale count to 0.
- MTIP:
  - Combinational: (mtime >= mtimecmp), unsigned 64-bit compare.
  - Cleared only by raising mtimecmp or lowering mtime; irq_ack does not clear it.
- MEIP:
  - Set on a rising edge of the (optionally synchronised) ext_irq.
  - Cleared by irq_ack when the registered cause was 32'h8000_000B, or by a STATUS write with wdata[1]=1.
  - Set has priority over clear in the same cycle.
- cause update, every clock:
  - if MEIP & EIE: 32'h8000_000B
  - else if MTIP & TIE: 32'h8000_0007
  - else: 32'h0
  - External has priority over timer.
- Latency:
  - cause reflects the pending/enable state of the previous cycle (1-cycle register).
  - Timer: mtime reaching mtimecmp gives irq=1 one cycle later.
- Simultaneous bus write and irq_ack: both take effect; cause is recomputed from post-update state on the next edge.
- Reset asserted mid-count: all state returns to reset values immediately (asynchronous); no interrupt is emitted on reset release until the conditions recur.

Optional Feature:
- Macro: EXT_IRQ_SYNC_EN
- Defined: ext_irq passes through a 2-flop synchroniser before edge detection; edge to MEIP takes 3 cycles, irq asserts on the 4th edge.
- Undefined: ext_irq feeds the edge-detect flop directly; edge to MEIP takes 1 cycle, irq asserts on the 2nd edge.
- Register map and priority are identical in both builds.

Test Plan:
- Reset, then PRESCALE=1, write mtimecmp=10, CTRL=3 -> irq rises exactly one cycle after mtime reads 10; cause=32'h8000_0007; irq_ack leaves cause unchanged.
- With the timer irq pending, write MTIMECMP_LO=1000 -> MTIP=0 and cause=0 on the next cycle.
- PRESCALE=4, TEN=1 for 40 cycles -> mtime=10.
- Write mtime=64'hFFFF_FFFF_FFFF_FFFF, run -> mtime wraps to 0 and MTIP reflects the unsigned compare.
- CTRL=7, both sources pending -> cause=32'h8000_000B; irq_ack -> MEIP clears and cause=32'h8000_0007 on the next cycle.
- ext_irq pulse with EIE=0 -> MEIP=1 in STATUS, irq=0; write STATUS=2 -> MEIP=0. Repeat with EXT_IRQ_SYNC_EN defined and check the 3-cycle vs 1-cycle latency.
- Assert rst while cause=32'h8000_0007 -> cause=0, mtime=0 and mtimecmp=MTIMECMP_RST immediately, without waiting for a clock edge.
